// File: rtl/if_id_stage.sv
// IF/ID pipeline register with early JAL redirect and FENCE.I drain hold.
// Optional BRANCH_PREDICT_EN: backward conditional branches also early-redirect.
module if_id_stage #(
  parameter int unsigned FENCE_DRAIN = 3,
  parameter logic [31:0] NOP_INSTR   = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] IF_PC,
  input  logic [31:0] IF_instr,
  input  logic        stall,
  input  logic        flush,
  output logic [31:0] ID_PC,
  output logic [31:0] ID_instr,
  output logic        ID_valid,
  output logic        ID_predicted,
  output logic [31:0] PC_Jump,
  output logic        jump_taken,
  output logic        fence
);

  typedef enum logic {RUN, FENCE_WAIT} state_t;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [31:0] r_instr, w_instr_nxt;
  logic        r_valid, w_valid_nxt;
  logic        r_pred, w_pred_nxt;

  logic        w_fence_hit;
  logic        w_early_hit;
  logic [31:0] w_imm;
  logic [31:0] w_j_imm;
  logic        w_is_jal;

  assign w_is_jal    = (r_instr[6:0] == 7'b1101111);
  assign w_j_imm     = {{12{r_instr[31]}}, r_instr[19:12], r_instr[20], r_instr[30:21], 1'b0};
  assign w_fence_hit = r_valid && (r_instr == 32'h0000100F);

`ifdef BRANCH_PREDICT_EN
  logic        w_is_bwd_br;
  logic [31:0] w_b_imm;
  assign w_b_imm     = {{20{r_instr[31]}}, r_instr[7], r_instr[30:25], r_instr[11:8], 1'b0};
  // Negative B-imm is exactly instr[31] set: predict backward branches taken.
  assign w_is_bwd_br = (r_instr[6:0] == 7'b1100011) && r_instr[31];
  assign w_early_hit = w_is_jal || w_is_bwd_br;
  assign w_imm       = w_is_jal ? w_j_imm : w_b_imm;
`else
  assign w_early_hit = w_is_jal;
  assign w_imm       = w_j_imm;
`endif

  assign jump_taken   = (r_state == RUN) && r_valid && !w_fence_hit && w_early_hit;
  assign PC_Jump      = jump_taken ? w_imm : '0;
  assign fence        = (r_state == FENCE_WAIT) || ((r_state == RUN) && w_fence_hit);
  assign ID_PC        = r_pc;
  assign ID_instr     = r_instr;
  assign ID_valid     = r_valid;
  assign ID_predicted = r_pred;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pc_nxt    = r_pc;
    w_instr_nxt = r_instr;
    w_valid_nxt = r_valid;
    w_pred_nxt  = r_pred;
    if (flush) begin
      w_instr_nxt = NOP_INSTR;
      w_valid_nxt = 1'b0;
      w_pred_nxt  = 1'b0;
      w_state_nxt = RUN;
      w_cnt_nxt   = '0;
    end else if (!stall) begin
      case (r_state)
        RUN: begin
          if (w_fence_hit) begin
            w_instr_nxt = NOP_INSTR;
            w_valid_nxt = 1'b0;
            w_pred_nxt  = 1'b0;
            w_state_nxt = FENCE_WAIT;
            w_cnt_nxt   = 4'(FENCE_DRAIN);
          end else if (jump_taken) begin
            // Bubble the wrong-path word; the pulse travels with the jump into EX.
            w_instr_nxt = NOP_INSTR;
            w_valid_nxt = 1'b0;
            w_pred_nxt  = 1'b1;
          end else begin
            w_pc_nxt    = IF_PC;
            w_instr_nxt = IF_instr;
            w_valid_nxt = 1'b1;
            w_pred_nxt  = 1'b0;
          end
        end
        FENCE_WAIT: begin
          w_instr_nxt = NOP_INSTR;
          w_valid_nxt = 1'b0;
          w_pred_nxt  = 1'b0;
          w_cnt_nxt   = r_cnt - 4'd1;
          if (r_cnt == 4'd1) w_state_nxt = RUN;
        end
        default: begin
          w_state_nxt = RUN;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RUN;
      r_cnt   <= '0;
      r_pc    <= '0;
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
      r_pred  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pc    <= w_pc_nxt;
      r_instr <= w_instr_nxt;
      r_valid <= w_valid_nxt;
      r_pred  <= w_pred_nxt;
    end
  end

endmodule

// File: tb/tb_if_id_stage.sv
// Directed + randomized bench for if_id_stage against a cycle-level reference model.
module tb_if_id_stage;

  localparam int unsigned DRAIN = 3;
  localparam logic [31:0] NOP   = 32'h00000013;
  localparam logic [31:0] FENCEI = 32'h0000100F;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] IF_PC = '0;
  logic [31:0] IF_instr = '0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] ID_PC, ID_instr, PC_Jump;
  logic        ID_valid, ID_predicted, jump_taken, fence;

  int checks = 0;
  int failures = 0;

  // reference model state
  logic [31:0] m_pc, m_instr;
  logic        m_valid, m_pred;
  int          m_drain;   // remaining fence-wait cycles; 0 means normal running

  if_id_stage #(.FENCE_DRAIN(DRAIN), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .IF_PC(IF_PC), .IF_instr(IF_instr),
    .stall(stall), .flush(flush), .ID_PC(ID_PC), .ID_instr(ID_instr),
    .ID_valid(ID_valid), .ID_predicted(ID_predicted), .PC_Jump(PC_Jump),
    .jump_taken(jump_taken), .fence(fence)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int jal_offset(input logic [31:0] w);
    int v;
    v = int'(w[30:21]) * 2 + int'(w[20]) * 2048 + int'(w[19:12]) * 4096;
    if (w[31]) v = v - 1048576;
    return v;
  endfunction

  function automatic int br_offset(input logic [31:0] w);
    int v;
    v = int'(w[11:8]) * 2 + int'(w[30:25]) * 32 + int'(w[7]) * 2048;
    if (w[31]) v = v - 4096;
    return v;
  endfunction

  function automatic bit m_fence_hit();
    return (m_drain == 0) && m_valid && (m_instr == FENCEI);
  endfunction

  function automatic bit m_jump();
    bit hit;
    hit = (m_instr[6:0] == 7'h6F);
`ifdef BRANCH_PREDICT_EN
    if (m_instr[6:0] == 7'h63 && br_offset(m_instr) < 0) hit = 1'b1;
`endif
    return (m_drain == 0) && m_valid && !m_fence_hit() && hit;
  endfunction

  function automatic logic [31:0] m_pcjump();
    if (!m_jump()) return '0;
    if (m_instr[6:0] == 7'h6F) return jal_offset(m_instr);
    return br_offset(m_instr);
  endfunction

  task automatic model_reset();
    m_pc = '0; m_instr = NOP; m_valid = 1'b0; m_pred = 1'b0; m_drain = 0;
  endtask

  task automatic model_bubble(input bit pred);
    m_instr = NOP; m_valid = 1'b0; m_pred = pred;
  endtask

  task automatic model_edge(input logic [31:0] pc, input logic [31:0] ins, input bit st, input bit fl);
    if (fl) begin
      model_bubble(1'b0); m_drain = 0;
    end else if (st) begin
    end else if (m_drain > 0) begin
      model_bubble(1'b0); m_drain = m_drain - 1;
    end else if (m_fence_hit()) begin
      model_bubble(1'b0); m_drain = DRAIN;
    end else if (m_jump()) begin
      model_bubble(1'b1);
    end else begin
      m_pc = pc; m_instr = ins; m_valid = 1'b1; m_pred = 1'b0;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".ID_PC"}, ID_PC, m_pc);
    chk({tag, ".ID_instr"}, ID_instr, m_instr);
    chk({tag, ".ID_valid"}, 32'(ID_valid), 32'(m_valid));
    chk({tag, ".ID_predicted"}, 32'(ID_predicted), 32'(m_pred));
    chk({tag, ".jump_taken"}, 32'(jump_taken), 32'(m_jump()));
    chk({tag, ".PC_Jump"}, PC_Jump, m_pcjump());
    chk({tag, ".fence"}, 32'(fence), 32'((m_drain > 0) || m_fence_hit()));
  endtask

  // Drive inputs just after an edge, clock once, then check everything 1ns later.
  task automatic step(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                      input bit st, input bit fl);
    IF_PC = pc; IF_instr = ins; stall = st; flush = fl;
    @(posedge clk);
    model_edge(pc, ins, st, fl);
    #1;
    check_all(tag);
  endtask

  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 5))
      0: return {r[31:7], 7'h6F};
      1: return {r[31:15], 3'b000, r[11:7], 7'h63};
      2: return FENCEI;
      3: return NOP;
      default: return r;
    endcase
  endfunction

  initial begin
    int fence_cycles;
    model_reset();
    @(posedge clk);
    #1;
    check_all("reset_hold");
    rst = 1'b0;

    // async reset in mid-cycle after some activity, then first capture
    step("warm", 32'h100, 32'h00A00113, 0, 0);
    async_reset("async_rst");
    step("t1", 32'h0, 32'h00500093, 0, 0);
    chk("t1.ID_instr_const", ID_instr, 32'h00500093);
    chk("t1.ID_valid_const", 32'(ID_valid), 32'd1);

    // JAL x1,+16 at 0x20 redirects and bubbles its successor
    step("t2.load", 32'h20, 32'h010000EF, 0, 0);
    chk("t2.jump_taken_const", 32'(jump_taken), 32'd1);
    chk("t2.PC_Jump_const", PC_Jump, 32'h10);
    step("t2.redir", 32'h24, 32'h12345678, 0, 0);
    chk("t2.ID_instr_nop", ID_instr, 32'h13);
    chk("t2.ID_pred_pulse", 32'(ID_predicted), 32'd1);
    step("t2.after", 32'h30, 32'h00000013, 0, 0);

    // stall holds a JAL with jump_taken up
    step("t3.load", 32'h40, 32'h010000EF, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step("t3.stall", 32'h44, 32'hDEADBEEF, 1, 0);
      chk("t3.held_jump", 32'(jump_taken), 32'd1);
    end
    step("t3.release", 32'h44, 32'hDEADBEEF, 0, 0);
    chk("t3.bubbled", 32'(ID_valid), 32'd0);

    // FENCE.I drain: fence high for DRAIN+1 consecutive cycles
    step("t4.load", 32'h50, FENCEI, 0, 0);
    fence_cycles = 0;
    for (int i = 0; i < 6 && fence; i++) begin
      fence_cycles++;
      step("t4.drain", 32'h54, 32'h00700193, 0, 0);
    end
    chk("t4.fence_cycles", 32'(fence_cycles), 32'(DRAIN + 1));
    step("t4.capture", 32'h54, 32'h00700193, 0, 0);
    chk("t4.captured", ID_instr, 32'h00700193);

    // flush beats stall with a JAL in ID
    step("t5.load", 32'h60, 32'h010000EF, 0, 0);
    step("t5.flush", 32'h64, 32'h11111111, 1, 1);
    chk("t5.jump_off", 32'(jump_taken), 32'd0);

    // backward/forward conditional branches
    step("t6.neg", 32'h70, 32'hFE000CE3, 0, 0);
`ifdef BRANCH_PREDICT_EN
    chk("t6.neg_jump", 32'(jump_taken), 32'd1);
    chk("t6.neg_off", PC_Jump, 32'hFFFFFFF8);
`else
    chk("t6.neg_jump", 32'(jump_taken), 32'd0);
`endif
    step("t6.pos", 32'h74, 32'h00000463, 1, 1);
    step("t6.pos", 32'h74, 32'h00000463, 0, 0);
    chk("t6.pos_jump", 32'(jump_taken), 32'd0);

    // reset during fence drain
    step("t7.load", 32'h80, FENCEI, 0, 0);
    step("t7.drain", 32'h84, 32'h0, 0, 0);
    async_reset("t7.rst");
    chk("t7.fence_off", 32'(fence), 32'd0);
    step("t7.resume", 32'h0, 32'h00500093, 0, 0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      step("rand", $urandom & 32'hFFFFFFFC, rand_instr(),
           ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
